// File: rtl/jt900h_busctl_pkg.sv
// jt900h_busctl_pkg: shared types and constants for the jt900h bus controller.
//   state_t  - access sequencer states (IDLE/WAIT/DONE)
//   RD_FILL  - data returned to the CPU when a read is aborted by timeout
package jt900h_busctl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] RD_FILL = 16'hFFFF;

endpackage

// File: rtl/jt900h_busctl_if.sv
// jt900h_busctl_if: external 16-bit memory bus.
//   bus_addr  word address           (master -> slave)
//   bus_dout  write data             (master -> slave)
//   bus_we    byte write strobes     (master -> slave)
//   bus_cs    access request         (master -> slave)
//   bus_din   read data              (slave -> master)
//   bus_ok    ready / data valid     (slave -> master)
//   bus_tout  abort pulse            (master -> slave), only with
//             JT900H_BUSCTL_TIMEOUT_EN defined
interface jt900h_busctl_if;

  logic [22:0] bus_addr;
  logic [15:0] bus_dout;
  logic [1:0]  bus_we;
  logic        bus_cs;
  logic [15:0] bus_din;
  logic        bus_ok;
`ifdef JT900H_BUSCTL_TIMEOUT_EN
  logic        bus_tout;

  modport master (
    output bus_addr, bus_dout, bus_we, bus_cs, bus_tout,
    input  bus_din, bus_ok
  );
  modport slave (
    input  bus_addr, bus_dout, bus_we, bus_cs, bus_tout,
    output bus_din, bus_ok
  );
`else
  modport master (
    output bus_addr, bus_dout, bus_we, bus_cs,
    input  bus_din, bus_ok
  );
  modport slave (
    input  bus_addr, bus_dout, bus_we, bus_cs,
    output bus_din, bus_ok
  );
`endif

endinterface

// File: rtl/jt900h_busctl.sv
// jt900h_busctl: turns the RAM controller's zero-wait interface into a
// handshaked 16-bit bus access, stalling the CPU through cpu_cen until each
// access completes. A one-word read buffer lets repeated reads of the same
// word complete without touching the bus.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cen          global clock enable; all state advances only when high
//   cpu_cen      CPU clock enable, one enabled cycle per completed access
//   ram_addr     byte address from the RAM controller
//   ram_din      write data from the RAM controller
//   ram_we       byte write mask {hi,lo}, 0 = read
//   ram_dout     read data to the RAM controller
//   bus          external bus (jt900h_busctl_if.master)
//
// Parameters:
//   WAITS  minimum cen cycles per access before bus_ok is honoured (0..15)
//   TOUT   bus_ok timeout in cen cycles (timeout build only)
//
// Build option: JT900H_BUSCTL_TIMEOUT_EN aborts an access after TOUT cycles
// without bus_ok, returns RD_FILL for reads and pulses bus.bus_tout.
module jt900h_busctl
  import jt900h_busctl_pkg::*;
#(
  parameter int unsigned WAITS = 1,
  parameter int unsigned TOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  output logic        cpu_cen,
  input  logic [23:0] ram_addr,
  input  logic [15:0] ram_din,
  input  logic [1:0]  ram_we,
  output logic [15:0] ram_dout,
  jt900h_busctl_if.master bus
);

  localparam logic [3:0] WAITS_INIT = 4'(WAITS);
  localparam logic [7:0] TOUT_LAST  = 8'(TOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        buf_valid_q, buf_valid_d;
  logic [22:0] buf_addr_q, buf_addr_d;
  logic [15:0] dout_q, dout_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  we_q, we_d;
  logic        cs_q, cs_d;
  logic        hit;
  logic        rd_acc;
  logic        unused_bits;
`ifdef JT900H_BUSCTL_TIMEOUT_EN
  logic [7:0]  tcnt_q, tcnt_d;
  logic        tout_q, tout_d;
`endif

  // Byte address bit 0 selects nothing on a 16-bit bus.
  assign unused_bits = ^{ram_addr[0], TOUT_LAST};

  assign hit    = (ram_we == 2'b00) && buf_valid_q && (ram_addr[23:1] == buf_addr_q);
  // bus_we stays at the request mask for the whole access, so it also
  // tells read from write while in WAIT.
  assign rd_acc = (we_q == 2'b00);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    dout_d      = dout_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    cs_d        = cs_q;
`ifdef JT900H_BUSCTL_TIMEOUT_EN
    tcnt_d      = tcnt_q;
    tout_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = DONE;
        end else begin
          addr_d  = ram_addr[23:1];
          wdata_d = ram_din;
          we_d    = ram_we;
          cs_d    = 1'b1;
          cnt_d   = WAITS_INIT;
`ifdef JT900H_BUSCTL_TIMEOUT_EN
          tcnt_d  = '0;
`endif
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (bus.bus_ok) begin
          if (rd_acc) begin
            dout_d      = bus.bus_din;
            buf_addr_d  = addr_q;
            buf_valid_d = 1'b1;
          end else if (addr_q == buf_addr_q) begin
            buf_valid_d = 1'b0;
          end
          cs_d    = 1'b0;
          we_d    = '0;
          state_d = DONE;
        end
`ifdef JT900H_BUSCTL_TIMEOUT_EN
        else if (tcnt_q == TOUT_LAST) begin
          if (rd_acc) dout_d = RD_FILL;
          cs_d    = 1'b0;
          we_d    = '0;
          tout_d  = 1'b1;
          state_d = DONE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      dout_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= '0;
      cs_q        <= 1'b0;
`ifdef JT900H_BUSCTL_TIMEOUT_EN
      tcnt_q      <= '0;
      tout_q      <= 1'b0;
`endif
    end else if (cen) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      dout_q      <= dout_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cs_q        <= cs_d;
`ifdef JT900H_BUSCTL_TIMEOUT_EN
      tcnt_q      <= tcnt_d;
      tout_q      <= tout_d;
`endif
    end
  end

  assign cpu_cen      = cen && (state_q == DONE);
  assign ram_dout     = dout_q;
  assign bus.bus_addr = addr_q;
  assign bus.bus_dout = wdata_q;
  assign bus.bus_we   = we_q;
  assign bus.bus_cs   = cs_q;
`ifdef JT900H_BUSCTL_TIMEOUT_EN
  assign bus.bus_tout = tout_q;
`endif

endmodule

// File: tb/tb_jt900h_busctl.sv
// tb_jt900h_busctl: directed bench for jt900h_busctl with a transaction-level
// reference model and a per-cycle compare process.
module tb_jt900h_busctl;

  localparam int WAITS = 1;
  localparam int TOUT  = 4;
`ifdef JT900H_BUSCTL_TIMEOUT_EN
  localparam int LOW4 = 3;
`else
  localparam int LOW4 = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic        cpu_cen;
  logic [23:0] ram_addr = '0;
  logic [15:0] ram_din = '0;
  logic [1:0]  ram_we = '0;
  logic [15:0] ram_dout;

  jt900h_busctl_if bif ();

  jt900h_busctl #(.WAITS(WAITS), .TOUT(TOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .cpu_cen  (cpu_cen),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout),
    .bus      (bif.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // cen generator: steady high, or alternating when cen_tog is set.
  bit cen_run = 1'b0;
  bit cen_tog = 1'b0;
  always @(posedge clk) begin
    #2;
    if (!cen_run)     cen = 1'b0;
    else if (cen_tog) cen = ~cen;
    else              cen = 1'b1;
  end

  // Reference model: an access is either answered from the buffered word
  // or occupies the bus until bus_ok is seen after WAITS elapsed cycles.
  int          cyc = 0;
  int          m_t0 = 0;
  int          m_el = 0;
  int          m_stall = 0;
  bit          m_pulse = 1'b0;
  bit          m_bus = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_abort = 1'b0;
  logic [22:0] m_baddr = '0;
  logic [22:0] m_addr = '0;
  logic [1:0]  m_we = '0;
  logic [15:0] m_wd = '0;
  logic [15:0] m_rdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pulse = 1'b0; m_bus = 1'b0; m_valid = 1'b0; m_abort = 1'b0;
      m_baddr = '0; m_rdata = '0; m_we = '0;
    end else if (cen) begin
      cyc++;
      if (m_pulse) begin
        m_pulse = 1'b0;
        m_abort = 1'b0;
      end else if (!m_bus) begin
        m_t0 = cyc;
        if (ram_we == 2'b00 && m_valid && ram_addr[23:1] == m_baddr) begin
          m_pulse = 1'b1;
        end else begin
          m_bus = 1'b1; m_el = 0; m_stall = 0;
          m_addr = ram_addr[23:1]; m_we = ram_we; m_wd = ram_din;
        end
      end else begin
        m_el++;
        if (m_el > WAITS) begin
          if (bif.bus_ok) begin
            if (m_we == 2'b00) begin
              m_rdata = bif.bus_din; m_baddr = m_addr; m_valid = 1'b1;
            end else if (m_addr == m_baddr) begin
              m_valid = 1'b0;
            end
            m_bus = 1'b0; m_we = '0; m_pulse = 1'b1;
          end else begin
            m_stall++;
`ifdef JT900H_BUSCTL_TIMEOUT_EN
            if (m_stall == TOUT) begin
              if (m_we == 2'b00) m_rdata = 16'hFFFF;
              m_bus = 1'b0; m_we = '0; m_pulse = 1'b1; m_abort = 1'b1;
            end
`endif
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("cpu_cen", 32'(cpu_cen), 32'(cen && m_pulse));
    check("bus_cs", 32'(bif.bus_cs), 32'(m_bus));
    if (m_bus) begin
      check("bus_addr", 32'(bif.bus_addr), 32'(m_addr));
      check("bus_we", 32'(bif.bus_we), 32'(m_we));
      check("bus_dout", 32'(bif.bus_dout), 32'(m_wd));
    end else begin
      check("bus_we_idle", 32'(bif.bus_we), 32'd0);
    end
    check("ram_dout", 32'(ram_dout), 32'(m_rdata));
`ifdef JT900H_BUSCTL_TIMEOUT_EN
    check("bus_tout", 32'(bif.bus_tout), 32'(m_pulse && m_abort));
`endif
  end

  task automatic req(input logic [23:0] a, input logic [1:0] we, input logic [15:0] d);
    ram_addr = a;
    ram_we   = we;
    ram_din  = d;
  endtask

  // Waits for the cpu_cen pulse; reports latency in cen cycles from the
  // request sample, bus_cs cycles seen, and the bus fields while cs was high.
  task automatic wait_done(output int lat, output int n_cs, output logic [22:0] s_addr,
                           output logic [1:0] s_we, output logic [15:0] s_dout,
                           output logic s_tout);
    lat = -1; n_cs = 0; s_addr = '0; s_we = '0; s_dout = '0; s_tout = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bif.bus_cs) begin
        n_cs++;
        s_addr = bif.bus_addr; s_we = bif.bus_we; s_dout = bif.bus_dout;
      end
      if (cpu_cen) begin
        lat = cyc - m_t0 + 1;
`ifdef JT900H_BUSCTL_TIMEOUT_EN
        s_tout = bif.bus_tout;
`endif
        break;
      end
    end
    if (lat < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_done: no cpu_cen pulse within 300 cycles");
    end
  endtask

  int          lat, ncs, k;
  logic [22:0] sa;
  logic [1:0]  sw;
  logic [15:0] sd;
  logic        st;

  task automatic next_slot();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bif.bus_ok  = 1'b1;
    bif.bus_din = 16'h1234;
    cen_run     = 1'b1;
    req(24'h000100, 2'b00, 16'h0000);
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(bif.bus_cs), 32'd0);
    check("rst_cpu_cen", 32'(cpu_cen), 32'd0);
    check("rst_dout", 32'(ram_dout), 32'd0);
    check("rst_addr", 32'(bif.bus_addr), 32'd0);
    next_slot();
    rst_n = 1'b1;

    // 1: first read misses
    wait_done(lat, ncs, sa, sw, sd, st);
    check("t1_lat", 32'(lat), 32'd3);
    check("t1_ncs", 32'(ncs), 32'd2);
    check("t1_addr", 32'(sa), 32'h80);
    check("t1_dout", 32'(ram_dout), 32'h1234);
    check("t1_model", 32'(m_rdata), 32'h1234);

    // 2: odd byte of the same word hits the buffer
    next_slot();
    bif.bus_din = 16'hDEAD;
    req(24'h000101, 2'b00, 16'h0000);
    wait_done(lat, ncs, sa, sw, sd, st);
    check("t2_lat", 32'(lat), 32'd1);
    check("t2_ncs", 32'(ncs), 32'd0);
    check("t2_dout", 32'(ram_dout), 32'h1234);

    // 3: high-byte write to the buffered word invalidates it
    next_slot();
    req(24'h000101, 2'b10, 16'hAB00);
    wait_done(lat, ncs, sa, sw, sd, st);
    check("t3_lat", 32'(lat), 32'd3);
    check("t3_we", 32'(sw), 32'h2);
    check("t3_wdata", 32'(sd), 32'hAB00);
    check("t3_dout", 32'(ram_dout), 32'h1234);
    next_slot();
    bif.bus_din = 16'h5678;
    req(24'h000100, 2'b00, 16'h0000);
    wait_done(lat, ncs, sa, sw, sd, st);
    check("t3_rd_ncs", 32'(ncs), 32'd2);
    check("t3_rd_dout", 32'(ram_dout), 32'h5678);

    // 3b: low-byte write elsewhere leaves the buffer valid
    next_slot();
    req(24'h000300, 2'b01, 16'h00CD);
    wait_done(lat, ncs, sa, sw, sd, st);
    check("t3b_we", 32'(sw), 32'h1);
    check("t3b_addr", 32'(sa), 32'h180);
    next_slot();
    bif.bus_din = 16'hBEEF;
    req(24'h000100, 2'b00, 16'h0000);
    wait_done(lat, ncs, sa, sw, sd, st);
    check("t3b_hit_lat", 32'(lat), 32'd1);
    check("t3b_hit_dout", 32'(ram_dout), 32'h5678);

    // 4a: bus_ok held low after the wait count expires
    next_slot();
    bif.bus_ok  = 1'b0;
    bif.bus_din = 16'h9ABC;
    req(24'h000400, 2'b00, 16'h0000);
    k = 0;
    while (k < 2 + LOW4) begin
      @(posedge clk);
      if (cen) k++;
    end
    #2 bif.bus_ok = 1'b1;
    wait_done(lat, ncs, sa, sw, sd, st);
    check("t4a_lat", 32'(lat), 32'(WAITS + 2 + LOW4));
    check("t4a_dout", 32'(ram_dout), 32'h9ABC);

    // 4b: same with cen alternating
    next_slot();
    cen_tog     = 1'b1;
    bif.bus_ok  = 1'b0;
    bif.bus_din = 16'h1357;
    req(24'h000600, 2'b00, 16'h0000);
    k = 0;
    while (k < 2 + 3) begin
      @(posedge clk);
      if (cen) k++;
    end
    #2 bif.bus_ok = 1'b1;
    wait_done(lat, ncs, sa, sw, sd, st);
    check("t4b_lat", 32'(lat), 32'(WAITS + 2 + 3));
    check("t4b_dout", 32'(ram_dout), 32'h1357);
    cen_tog = 1'b0;

    // 5: reset during an access drops cs and empties the buffer
    next_slot();
    bif.bus_din = 16'h2468;
    req(24'h000200, 2'b00, 16'h0000);
    wait_done(lat, ncs, sa, sw, sd, st);
    check("t5_fill", 32'(ram_dout), 32'h2468);
    next_slot();
    bif.bus_din = 16'h1111;
    req(24'h000800, 2'b00, 16'h0000);
    k = 0;
    while (!bif.bus_cs && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t5_cs_before", 32'(bif.bus_cs), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_cs_async", 32'(bif.bus_cs), 32'd0);
    check("t5_dout_async", 32'(ram_dout), 32'd0);
    next_slot();
    bif.bus_din = 16'h2468;
    req(24'h000200, 2'b00, 16'h0000);
    rst_n = 1'b1;
    wait_done(lat, ncs, sa, sw, sd, st);
    check("t5_miss_ncs", 32'(ncs), 32'd2);
    check("t5_miss_lat", 32'(lat), 32'd3);

`ifdef JT900H_BUSCTL_TIMEOUT_EN
    // 6: bus_ok never arrives
    next_slot();
    bif.bus_ok = 1'b0;
    req(24'h000A00, 2'b00, 16'h0000);
    wait_done(lat, ncs, sa, sw, sd, st);
    check("t6_lat", 32'(lat), 32'(WAITS + 1 + TOUT));
    check("t6_dout", 32'(ram_dout), 32'hFFFF);
    check("t6_tout", 32'(st), 32'd1);
    bif.bus_ok = 1'b1;
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
